rr_sel_arbiter: RTL and testbench
=================================

# rr_sel_arbiter

Clocked round-robin arbiter that shares one 4:1 datapath select among four request lines `x[3:0]`. It produces the `s1`/`s0` select code and a one-hot grant for the mux stage that the combinational select controller drives today. It adds fairness, grant holding and a bounded hold time so that no single requester can starve the others.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner. Legal range is 2..255.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `x`  in  4: request lines; `x[i]`=1 means requester i wants the datapath.
- `s1`  out  1: select MSB; `{s1,s0}` is the current owner index.
- `s0`  out  1: select LSB.
- `gnt`  out  4: one-hot grant; all zero when no owner.
- `busy`  out  1: 1 while a grant is active (`|gnt`).
- `done`  out  1: one-cycle pulse in the cycle immediately after a grant ends.

## Operation

- The FSM has two states, IDLE and GRANT. All outputs are registered.
- State held by the block:
  - `ptr[1:0]`, the last owner; reset value 3.
  - `own[1:0]`, the current owner.
  - `hcnt[7:0]`, the hold counter.
- Arbitration in IDLE:
  - If `x` is nonzero, pick the first set bit scanning `ptr+1, ptr+2, ptr+3, ptr+4`, with mod-4 wrap.
  - Load `own`, clear `hcnt`, go to GRANT.
  - With `ptr`=3, the priority order is 0,1,2,3.
- In GRANT:
  - Outputs: `gnt[own]`=1, `{s1,s0}`=`own`, `busy`=1.
  - `hcnt` increments each cycle and saturates.
- Release from GRANT, evaluated on the current cycle's inputs:
  - Trigger (a): `x[own]`=0.
  - Trigger (b): the timeout condition (see Configuration).
  - On release: `ptr`<=`own`, go to IDLE.
  - The next cycle has `gnt`=0, `busy`=0 and `done`=1.
- Turnaround: the IDLE cycle after a release performs a fresh arbitration. There is therefore exactly one dead cycle between consecutive grants, and that cycle is also the cycle in which `done` is high.
- Request changes from non-owners during GRANT are ignored. They are considered only at the next IDLE arbitration.
- `{s1,s0}` holds the last owner index while idle. It is not forced to 00.
- Reset values:
  - `gnt`=0000, `s1`=0, `s0`=0, `busy`=0, `done`=0.
  - State IDLE, `ptr`=3, `own`=0, `hcnt`=0.

## Timing

- Grant latency: `x[i]` high in IDLE cycle n gives `gnt[i]`=1 in cycle n+1.
- Release latency: `x[own]` low in GRANT cycle m gives `gnt`=0 and `done`=1 in cycle m+1.
  - A request pulse of 1 cycle is therefore granted for exactly 1 cycle, and only if it is still high in that grant cycle. Otherwise the grant is 1 cycle and released.
- Simultaneous requests in IDLE: only the round-robin winner is granted. The losers wait for the next IDLE cycle.
- Owner drops its request in the same cycle as the timeout: a single release with a single `done` pulse.
- Reset asserted mid-grant: in the following cycle all outputs take their reset values. No `done` pulse is issued.
- `x`=0000 in IDLE: stay in IDLE with no outputs changing. `done`=0, except in the one cycle following a release.

## Configuration

- Macro: `RR_SEL_HOLD_LIMIT_EN`.
- Defined:
  - Trigger (b) is active. Release occurs when `hcnt`==`MAX_HOLD`-1, so `gnt` is high for at most `MAX_HOLD` consecutive cycles.
  - The preempted owner becomes lowest priority. If it is the only requester, it is re-granted after the 1 dead cycle.
- Undefined:
  - `hcnt` is not implemented.
  - A grant is held until the owner's request drops, with no upper bound.

## Test plan

- Reset then single request:
  - Stimulus: reset 2 cycles, then `x`=0100 held 3 cycles, then `x`=0000.
  - Response: `gnt`=0100 and `{s1,s0}`=10 from the cycle after `x` rises, for 3 cycles; `done`=1 for one cycle.
- Simultaneous requests:
  - Stimulus: `x`=1111 held continuously, each owner drops its request after 2 grant cycles and re-raises it next cycle.
  - Response: grant order 0,1,2,3,0, with exactly one dead cycle between grants.
- Hold limit (macro defined, `MAX_HOLD`=8):
  - Stimulus: `x`=0010 held for 30 cycles.
  - Response: `gnt`=0010 for 8 cycles, 1 dead cycle with `done`=1, then repeating.
  - With the macro undefined: `gnt`=0010 for all 30 cycles.
- Reset mid-grant:
  - Stimulus: owner 3 granted, `reset` pulsed for 1 cycle.
  - Response: next cycle `gnt`=0000, `s1`=`s0`=0, `done`=0; next arbitration of `x`=1001 grants 0.
- Non-owner churn:
  - Stimulus: owner 1 holding, `x[2]` toggles every cycle.
  - Response: `gnt` stays 0010 until `x[1]` drops; the next arbitration picks 2 if `x[2]` is high in that IDLE cycle.

Source files
------------

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 select ({s1,s0}) plus one-hot grant, with registered outputs.
// Define RR_SEL_HOLD_LIMIT_EN to bound each grant to MAX_HOLD consecutive cycles.
module rr_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] x,
  output logic       s1,
  output logic       s0,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       done
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_sel_arbiter: MAX_HOLD must be in 2..255");
  end

  logic [0:0] r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_own;
  logic [1:0] r_sel;
  logic [3:0] r_gnt;
  logic       r_busy;
  logic       r_done;

  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_release;

`ifdef RR_SEL_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hcnt;
`endif

  // Scan ptr+1 .. ptr+4 (mod 4); the last owner therefore has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_idx = r_ptr + i[1:0];
      if (!w_found && x[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
`ifdef RR_SEL_HOLD_LIMIT_EN
    w_release = !x[r_own] || (r_hcnt == HOLD_LAST);
`else
    w_release = !x[r_own];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd3;
      r_own   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef RR_SEL_HOLD_LIMIT_EN
      r_hcnt  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_own   <= w_win;
            r_sel   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_busy  <= 1'b1;
`ifdef RR_SEL_HOLD_LIMIT_EN
            r_hcnt  <= '0;
`endif
          end
        end
        default: begin
`ifdef RR_SEL_HOLD_LIMIT_EN
          if (r_hcnt != 8'hFF) r_hcnt <= r_hcnt + 8'd1;
`endif
          // Select code is left at the last owner after release.
          if (w_release) begin
            r_state <= S_IDLE;
            r_ptr   <= r_own;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign s1   = r_sel[1];
  assign s0   = r_sel[0];
  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed scenarios plus random traffic against a
// cycle-level behavioural model of the round-robin rules.
module tb_rr_sel_arbiter;

  localparam int MH = 8;
`ifdef RR_SEL_HOLD_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] x;
  logic       s1, s0, busy, done;
  logic [3:0] gnt;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc_no = 0;

  // Model: owner index or -1, last owner, cycles held so far, done flag, select value.
  int m_owner, m_last, m_held, m_sel;
  bit m_done;

  rr_sel_arbiter #(.MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .x(x), .s1(s1), .s0(s0),
    .gnt(gnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void model_step(input logic [3:0] xv, input logic rv);
    int cand;
    if (rv) begin
      m_owner = -1; m_last = 3; m_held = 0; m_done = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      m_done = 0;
      for (int k = 1; k <= 4; k++) begin
        cand = (m_last + k) % 4;
        if (m_owner < 0 && xv[cand]) begin
          m_owner = cand; m_sel = cand; m_held = 1;
        end
      end
    end else if (!xv[m_owner] || (LIMIT && m_held >= MH)) begin
      m_last = m_owner; m_owner = -1; m_done = 1;
    end else begin
      m_held++; m_done = 0;
    end
  endfunction

  function automatic logic [7:0] m_exp();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'h0 : (4'b0001 << m_owner);
    return {g, 2'(m_sel), (m_owner >= 0), m_done};
  endfunction

  function automatic logic [7:0] obs();
    return {gnt, s1, s0, busy, done};
  endfunction

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic [3:0] xv, input logic rv);
    x = xv; reset = rv;
    @(posedge clk);
    model_step(xv, rv);
    #1;
    cyc_no++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(4'b0000, 1'b1);
      n_cmp++;
      if (obs() !== 8'h00) begin
        n_mis++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", cyc_no, obs(), 8'h00);
      end
    end
  endtask

  task automatic test_single();
    int on_cnt = 0, done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc((i < 3) ? 4'b0100 : 4'b0000, 1'b0);
      n_cmp++;
      if (obs() !== m_exp()) begin
        n_mis++;
        $display("FAIL single cyc=%0d got=%b exp=%b", cyc_no, obs(), m_exp());
      end
      if (gnt === 4'b0100 && {s1, s0} === 2'b10) on_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    n_cmp++;
    if (on_cnt != 3 || done_cnt != 1) begin
      n_mis++;
      $display("FAIL single_counts got on=%0d done=%0d exp on=3 done=1", on_cnt, done_cnt);
    end
  endtask

  task automatic test_simultaneous();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] xv, prev_g;
    cyc(4'b0000, 1'b1);
    prev_g = 4'h0;
    for (int i = 0; i < 40 && order.size() < 5; i++) begin
      xv = 4'b1111;
      if (m_owner >= 0 && m_held == 2) xv[m_owner] = 1'b0;
      cyc(xv, 1'b0);
      n_cmp++;
      if (obs() !== m_exp()) begin
        n_mis++;
        $display("FAIL simul cyc=%0d got=%b exp=%b", cyc_no, obs(), m_exp());
      end
      if (gnt != 4'h0 && prev_g == 4'h0)
        for (int b = 0; b < 4; b++) if (gnt[b]) order.push_back(b);
      prev_g = gnt;
    end
    n_cmp++;
    if (order.size() != 5) begin
      n_mis++;
      $display("FAIL simul_count got=%0d exp=5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (order[k] != exp_order[k]) begin
          n_mis++;
          $display("FAIL simul_order idx=%0d got=%0d exp=%0d", k, order[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_hold_limit();
    int on_cnt = 0, exp_on;
    cyc(4'b0000, 1'b1);
    for (int i = 0; i < 30; i++) begin
      cyc(4'b0010, 1'b0);
      n_cmp++;
      if (obs() !== m_exp()) begin
        n_mis++;
        $display("FAIL hold cyc=%0d got=%b exp=%b", cyc_no, obs(), m_exp());
      end
      if (gnt === 4'b0010) on_cnt++;
    end
    exp_on = LIMIT ? (30 - 30 / (MH + 1)) : 30;
    n_cmp++;
    if (on_cnt != exp_on) begin
      n_mis++;
      $display("FAIL hold_count got=%0d exp=%0d", on_cnt, exp_on);
    end
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0);
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_mis++;
      $display("FAIL rstmid_pre got=%b exp=1000", gnt);
    end
    cyc(4'b1000, 1'b1);
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_mis++;
      $display("FAIL rstmid_out got=%b exp=%b", obs(), 8'h00);
    end
    cyc(4'b1001, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0001 || {s1, s0} !== 2'b00 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL rstmid_arb got gnt=%b sel=%b busy=%b exp gnt=0001 sel=00 busy=1", gnt, {s1, s0}, busy);
    end
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
  endtask

  task automatic test_churn();
    logic t = 1'b0;
    cyc(4'b0000, 1'b1);
    cyc(4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      t = ~t;
      cyc({1'b0, t, 2'b10}, 1'b0);
      n_cmp++;
      if (gnt !== 4'b0010) begin
        n_mis++;
        $display("FAIL churn_hold cyc=%0d got=%b exp=0010", cyc_no, gnt);
      end
    end
    cyc(4'b0000, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0000 || done !== 1'b1) begin
      n_mis++;
      $display("FAIL churn_rel got gnt=%b done=%b exp gnt=0000 done=1", gnt, done);
    end
    cyc(4'b0101, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0100 || {s1, s0} !== 2'b10) begin
      n_mis++;
      $display("FAIL churn_next got gnt=%b sel=%b exp gnt=0100 sel=10", gnt, {s1, s0});
    end
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] xv;
    logic rv;
    cyc(4'b0000, 1'b1);
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 59) == 0);
      // Bias towards holding requests so long grants and timeouts occur.
      xv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (x | 4'($urandom_range(0, 1) << $urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) xv = 4'h0;
      cyc(xv, rv);
      n_cmp++;
      if (obs() !== m_exp()) begin
        n_mis++;
        $display("FAIL random cyc=%0d x=%b rst=%b got=%b exp=%b", cyc_no, xv, rv, obs(), m_exp());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    x = 4'h0;
    m_owner = -1; m_last = 3; m_held = 0; m_done = 0; m_sel = 0;
    #2;
    test_reset();
    test_single();
    test_simultaneous();
    test_hold_limit();
    test_reset_mid();
    test_churn();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
